// File: rtl/lamp_pkg.sv
// Shared types and constants for the lamp driver and its pass-vector decoder.
// Lamp codes are {red, yellow, green}; direction indices are J = 0, P = 1, C = 2.
package lamp_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FAULT  = 2'd3
    } lamp_state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [1:0] DIR_J = 2'd0;
    localparam logic [1:0] DIR_P = 2'd1;
    localparam logic [1:0] DIR_C = 2'd2;

    // Lamp shown by direction `dir` when the sequencer is in `st` serving `active`.
    function automatic logic [2:0] lamp_code(
        input lamp_state_t st,
        input logic [1:0]  dir,
        input logic [1:0]  active,
        input logic        blink
    );
        logic [2:0] code;
        case (st)
            ST_ALLRED: code = LAMP_RED;
            ST_GREEN:  code = (dir == active) ? LAMP_GRN : LAMP_RED;
            ST_YELLOW: code = (dir == active) ? LAMP_YEL : LAMP_RED;
            ST_FAULT:  code = blink ? LAMP_YEL : LAMP_OFF;
            default:   code = LAMP_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lamp_driver_pass_check.sv
// Combinational decode of the pass vector {C, P, J} into one-hot / none / multi
// flags plus the index of the set bit (J when the vector is not one-hot).
module pass_check
    import lamp_pkg::*;
(
    input  logic [2:0] pv,
    output logic       one_hot,
    output logic       none,
    output logic       multi,
    output logic [1:0] idx
);

    logic [1:0] count_s;

    // Population count and classification of the pass vector.
    always_comb begin
        count_s = {1'b0, pv[0]} + {1'b0, pv[1]} + {1'b0, pv[2]};
        none    = (count_s == 2'd0);
        one_hot = (count_s == 2'd1);
        multi   = (count_s >= 2'd2);
    end

    // Index of the single set bit.
    always_comb begin
        case (pv)
            3'b001:  idx = DIR_J;
            3'b010:  idx = DIR_P;
            3'b100:  idx = DIR_C;
            default: idx = DIR_J;
        endcase
    end

endmodule

// File: rtl/lamp_driver.sv
// Lamp sequencer: turns the controller's pass levels into red/yellow/green lamps
// with yellow and all-red clearance phases, plus a latched interlock fault.
module lamp_driver
    import lamp_pkg::*;
#(
    parameter int YEL_T = 3,
    parameter int CLR_T = 1,
    parameter int TW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          J,
    input  logic          P,
    input  logic          C,
    output logic [2:0]    j_lamp,
    output logic [2:0]    p_lamp,
    output logic [2:0]    c_lamp,
    output logic [TW-1:0] remain,
    output logic          fault
);

    localparam logic [TW-1:0] YEL_V  = TW'(YEL_T);
    localparam logic [TW-1:0] CLR_V  = TW'(CLR_T);
    localparam logic [TW-1:0] ZERO_V = {TW{1'b0}};
    localparam logic [TW-1:0] ONE_V  = {{(TW-1){1'b0}}, 1'b1};

    logic [2:0]  pv_s;
    logic        one_hot_s;
    logic        none_s;
    logic        multi_s;
    logic [1:0]  idx_s;
    logic        pass_own_s;

    lamp_state_t state_r;
    lamp_state_t state_s;
    logic [1:0]  dir_r;
    logic [1:0]  dir_s;
    logic [TW-1:0] remain_r;
    logic [TW-1:0] remain_s;
    logic        blink_r;
    logic        blink_s;
    logic        fault_r;
    logic [2:0]  j_lamp_r;
    logic [2:0]  p_lamp_r;
    logic [2:0]  c_lamp_r;

    assign pv_s = {C, P, J};

    pass_check u_pass_check (
        .pv      (pv_s),
        .one_hot (one_hot_s),
        .none    (none_s),
        .multi   (multi_s),
        .idx     (idx_s)
    );

    // Pass level of the direction currently being served.
    always_comb begin
        case (dir_r)
            DIR_J:   pass_own_s = J;
            DIR_P:   pass_own_s = P;
            DIR_C:   pass_own_s = C;
            default: pass_own_s = 1'b0;
        endcase
    end

    // Next-state decision; the interlock check overrides every other transition.
    always_comb begin
        state_s  = state_r;
        dir_s    = dir_r;
        remain_s = remain_r;
        blink_s  = blink_r;
        if (state_r == ST_FAULT) begin
            remain_s = ZERO_V;
            if (tick) begin
                blink_s = ~blink_r;
            end else begin
                blink_s = blink_r;
            end
        end else if (multi_s) begin
            state_s  = ST_FAULT;
            remain_s = ZERO_V;
            blink_s  = 1'b1;
        end else begin
            case (state_r)
                ST_ALLRED: begin
                    if ((remain_r == ZERO_V) && one_hot_s) begin
                        state_s = ST_GREEN;
                        dir_s   = idx_s;
                    end else if (tick && (remain_r != ZERO_V)) begin
                        remain_s = remain_r - ONE_V;
                    end else begin
                        remain_s = remain_r;
                    end
                end
                ST_GREEN: begin
                    // A pass drop wins over a coincident tick: the tick is dropped.
                    if (none_s || !pass_own_s) begin
                        state_s  = ST_YELLOW;
                        remain_s = YEL_V;
                    end else begin
                        remain_s = ZERO_V;
                    end
                end
                ST_YELLOW: begin
                    if (tick) begin
                        if (remain_r <= ONE_V) begin
                            state_s  = ST_ALLRED;
                            remain_s = CLR_V;
                        end else begin
                            remain_s = remain_r - ONE_V;
                        end
                    end else begin
                        remain_s = remain_r;
                    end
                end
                default: begin
                    state_s  = ST_ALLRED;
                    remain_s = CLR_V;
                end
            endcase
        end
    end

    // State and output registers; lamps are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_ALLRED;
            dir_r    <= DIR_J;
            remain_r <= CLR_V;
            blink_r  <= 1'b0;
            fault_r  <= 1'b0;
            j_lamp_r <= LAMP_RED;
            p_lamp_r <= LAMP_RED;
            c_lamp_r <= LAMP_RED;
        end else begin
            state_r  <= state_s;
            dir_r    <= dir_s;
            remain_r <= remain_s;
            blink_r  <= blink_s;
            fault_r  <= (state_s == ST_FAULT);
            j_lamp_r <= lamp_code(state_s, DIR_J, dir_s, blink_s);
            p_lamp_r <= lamp_code(state_s, DIR_P, dir_s, blink_s);
            c_lamp_r <= lamp_code(state_s, DIR_C, dir_s, blink_s);
        end
    end

    assign j_lamp = j_lamp_r;
    assign p_lamp = p_lamp_r;
    assign c_lamp = c_lamp_r;
    assign remain = remain_r;
    assign fault  = fault_r;

endmodule

// File: tb/tb_lamp_driver.sv
// Self-checking bench for lamp_driver: directed scenarios with literal expectations,
// then randomized pass/tick/reset traffic against a behavioural model.
module tb_lamp_driver;

    localparam int YEL = 3;
    localparam int CLR = 1;
    localparam int TW  = 4;

    localparam int PH_ALLRED = 0;
    localparam int PH_GREEN  = 1;
    localparam int PH_YELLOW = 2;
    localparam int PH_FAULT  = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick  = 1'b0;
    logic          J = 1'b0;
    logic          P = 1'b0;
    logic          C = 1'b0;
    logic [2:0]    j_lamp;
    logic [2:0]    p_lamp;
    logic [2:0]    c_lamp;
    logic [TW-1:0] remain;
    logic          fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lamp_driver #(.YEL_T(YEL), .CLR_T(CLR), .TW(TW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .J      (J),
        .P      (P),
        .C      (C),
        .j_lamp (j_lamp),
        .p_lamp (p_lamp),
        .c_lamp (c_lamp),
        .remain (remain),
        .fault  (fault)
    );

    typedef struct {
        int phase;
        int d;
        int rem;
        bit blink;
    } model_t;

    model_t m = '{PH_ALLRED, 0, CLR, 1'b0};

    function automatic model_t model_next(model_t cur, bit r, bit [2:0] pv, bit tk);
        model_t n = cur;
        int cnt = int'(pv[0]) + int'(pv[1]) + int'(pv[2]);
        if (!r) begin
            n = '{PH_ALLRED, 0, CLR, 1'b0};
        end else if (cur.phase == PH_FAULT) begin
            if (tk) n.blink = !cur.blink;
        end else if (cnt > 1) begin
            n.phase = PH_FAULT;
            n.rem   = 0;
            n.blink = 1'b1;
        end else if (cur.phase == PH_ALLRED) begin
            if (cur.rem == 0 && cnt == 1) begin
                n.phase = PH_GREEN;
                for (int i = 0; i < 3; i++) if (pv[i]) n.d = i;
            end else if (tk && cur.rem > 0) begin
                n.rem = cur.rem - 1;
            end
        end else if (cur.phase == PH_GREEN) begin
            if (!pv[cur.d]) begin
                n.phase = PH_YELLOW;
                n.rem   = YEL;
            end
        end else if (cur.phase == PH_YELLOW) begin
            if (tk) begin
                if (cur.rem == 1) begin
                    n.phase = PH_ALLRED;
                    n.rem   = CLR;
                end else begin
                    n.rem = cur.rem - 1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [2:0] exp_lamp(model_t s, int i);
        if (s.phase == PH_FAULT) return s.blink ? 3'b010 : 3'b000;
        if (s.phase == PH_GREEN && s.d == i) return 3'b001;
        if (s.phase == PH_YELLOW && s.d == i) return 3'b010;
        return 3'b100;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model advances on the same edge as the DUT.
    always @(posedge clk) m <= model_next(m, rst_n, {C, P, J}, tick);

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("model_j_lamp", 32'(j_lamp), 32'(exp_lamp(m, 0)));
        check("model_p_lamp", 32'(p_lamp), 32'(exp_lamp(m, 1)));
        check("model_c_lamp", 32'(c_lamp), 32'(exp_lamp(m, 2)));
        check("model_remain", 32'(remain), 32'(m.rem));
        check("model_fault",  32'(fault),  32'(m.phase == PH_FAULT));
    end

    task automatic cycle(input bit r, input bit [2:0] pv, input bit tk);
        rst_n = r;
        {C, P, J} = pv;
        tick = tk;
        @(negedge clk);
    endtask

    initial begin
        bit [2:0] pv;
        bit       r;
        bit       tk;

        // Reset and first green
        cycle(1'b0, 3'b000, 1'b0);
        cycle(1'b0, 3'b000, 1'b0);
        check("rst_j", 32'(j_lamp), 32'd4);
        check("rst_p", 32'(p_lamp), 32'd4);
        check("rst_c", 32'(c_lamp), 32'd4);
        check("rst_remain", 32'(remain), 32'd1);
        check("rst_fault", 32'(fault), 32'd0);
        cycle(1'b1, 3'b001, 1'b1);
        check("clr_remain0", 32'(remain), 32'd0);
        check("clr_j_red", 32'(j_lamp), 32'd4);
        cycle(1'b1, 3'b001, 1'b0);
        check("first_green_j", 32'(j_lamp), 32'd1);

        // Handover J -> P with early P request
        cycle(1'b1, 3'b010, 1'b0);
        check("ho_j_yel", 32'(j_lamp), 32'd2);
        check("ho_remain3", 32'(remain), 32'd3);
        check("early_p_red", 32'(p_lamp), 32'd4);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'b010, 1'b1);
        check("ho_j_red", 32'(j_lamp), 32'd4);
        check("ho_remain1", 32'(remain), 32'd1);
        check("early_p_still_red", 32'(p_lamp), 32'd4);
        check("early_no_fault", 32'(fault), 32'd0);
        cycle(1'b1, 3'b010, 1'b1);
        check("clr_p_red", 32'(p_lamp), 32'd4);
        cycle(1'b1, 3'b010, 1'b0);
        check("ho_p_green", 32'(p_lamp), 32'd1);

        // Pass drop coincident with tick
        cycle(1'b1, 3'b000, 1'b1);
        check("drop_tick_remain3", 32'(remain), 32'd3);
        check("drop_tick_p_yel", 32'(p_lamp), 32'd2);

        // Reset mid-yellow
        cycle(1'b1, 3'b000, 1'b1);
        check("mid_yel_remain2", 32'(remain), 32'd2);
        cycle(1'b0, 3'b000, 1'b0);
        check("midrst_p", 32'(p_lamp), 32'd4);
        check("midrst_remain", 32'(remain), 32'd1);

        // Interlock violation and blinking
        cycle(1'b1, 3'b000, 1'b1);
        cycle(1'b1, 3'b100, 1'b0);
        check("c_green", 32'(c_lamp), 32'd1);
        cycle(1'b1, 3'b011, 1'b0);
        check("flt_fault", 32'(fault), 32'd1);
        check("flt_j_yel", 32'(j_lamp), 32'd2);
        check("flt_c_yel", 32'(c_lamp), 32'd2);
        check("flt_remain0", 32'(remain), 32'd0);
        cycle(1'b1, 3'b001, 1'b1);
        check("flt_blink_off", 32'(p_lamp), 32'd0);
        cycle(1'b1, 3'b001, 1'b0);
        check("flt_hold_off", 32'(j_lamp), 32'd0);
        check("flt_persist", 32'(fault), 32'd1);
        cycle(1'b1, 3'b001, 1'b1);
        check("flt_blink_on", 32'(c_lamp), 32'd2);
        cycle(1'b0, 3'b000, 1'b0);
        check("flt_rst_fault", 32'(fault), 32'd0);
        check("flt_rst_j", 32'(j_lamp), 32'd4);

        // Randomized traffic
        pv = 3'b000;
        for (int i = 0; i < 4000; i++) begin
            r  = 1'b1;
            if ($urandom_range(0, 299) == 0) r = 1'b0;
            if (m.phase == PH_FAULT && $urandom_range(0, 19) == 0) r = 1'b0;
            tk = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 29))
                0: pv = 3'b000;
                1: pv = 3'b001;
                2: pv = 3'b010;
                3: pv = 3'b100;
                4: begin
                    if ($urandom_range(0, 7) == 0) begin
                        case ($urandom_range(0, 3))
                            0: pv = 3'b011;
                            1: pv = 3'b101;
                            2: pv = 3'b110;
                            default: pv = 3'b111;
                        endcase
                    end
                end
                default: pv = pv;
            endcase
            cycle(r, pv, tk);
            if (pv > 3'b100 || pv == 3'b011) pv = 3'b000;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
